// File: rtl/mem_arb_pkg.sv
// Shared types and sizing helpers for the icache/dcache main-memory arbiter.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    ISSUE    = 2'd1,
    WAIT_RSP = 2'd2,
    DRAIN    = 2'd3
  } arb_state_t;

  typedef enum logic {
    REQ_IC = 1'b0,
    REQ_DC = 1'b1
  } req_id_t;

  localparam int TIMER_W = 8;

  // mem_req_info layout, MSB first: {addr, is_store, line data}
  function automatic int info_w(input int addr_w, input int line_w);
    return addr_w + 1 + line_w;
  endfunction

  function automatic int store_bit(input int line_w);
    return line_w;
  endfunction

endpackage

// File: rtl/mem_req_slot.sv
// One-entry pending request register; a new pulse beats the clear in the cycle
// the previous request is being answered.
module mem_req_slot #(
  parameter int W = 8
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         set,
  input  logic [W-1:0] set_data,
  input  logic         clear,
  output logic         pending,
  output logic [W-1:0] data
);

  logic accept;

  assign accept = set && (!pending || clear);

  always_ff @(posedge clock) begin
    if (reset) begin
      pending <= 1'b0;
      data    <= '0;
    end else begin
      if (accept) begin
        pending <= 1'b1;
        data    <= set_data;
      end else if (clear) begin
        pending <= 1'b0;
      end
      // A pulse onto a busy, unanswered slot is dropped.
      assert (!(set && pending && !clear));
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Round-robin arbiter sharing one valid/ready memory port between the icache and
// dcache miss paths, with response routing and timeout-to-bus-error conversion.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W         = 20,
  parameter int LINE_W         = 128,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     ic_req_valid,
  input  logic [ADDR_W-1:0]        ic_req_addr,
  output logic                     ic_rsp_valid,
  output logic [LINE_W-1:0]        ic_rsp_data,
  output logic                     ic_rsp_bus_error,
  input  logic                     dc_req_valid,
  input  logic [ADDR_W+LINE_W:0]   dc_req_info,
  output logic                     dc_rsp_valid,
  output logic [LINE_W-1:0]        dc_rsp_data,
  output logic                     dc_rsp_bus_error,
  output logic                     mem_req_valid,
  input  logic                     mem_req_ready,
  output logic [ADDR_W+LINE_W:0]   mem_req_info,
  input  logic                     mem_rsp_valid,
  input  logic [LINE_W-1:0]        mem_rsp_data,
  input  logic                     mem_rsp_bus_error
);

  localparam int INFO_W = info_w(ADDR_W, LINE_W);
  localparam logic [TIMER_W-1:0] TIMER_LAST = TIMER_W'(TIMEOUT_CYCLES - 1);

  arb_state_t          state_reg;
  req_id_t             grant_reg;
  req_id_t             last_reg;
  logic [TIMER_W-1:0]  timer_reg;

  logic                ic_pending;
  logic                dc_pending;
  logic [ADDR_W-1:0]   ic_addr;
  logic [INFO_W-1:0]   dc_info;
  logic                ic_avail;
  logic                dc_avail;
  logic                timeout_hit;
  req_id_t             pick;
  logic [LINE_W-1:0]   rsp_data;
  logic                rsp_err;

  mem_req_slot #(.W(ADDR_W)) ic_slot (
    .clock    (clock),
    .reset    (reset),
    .set      (ic_req_valid),
    .set_data (ic_req_addr),
    .clear    (ic_rsp_valid),
    .pending  (ic_pending),
    .data     (ic_addr)
  );

  mem_req_slot #(.W(INFO_W)) dc_slot (
    .clock    (clock),
    .reset    (reset),
    .set      (dc_req_valid),
    .set_data (dc_req_info),
    .clear    (dc_rsp_valid),
    .pending  (dc_pending),
    .data     (dc_info)
  );

  // A slot whose answer is on the bus this cycle is about to clear; don't re-grant it.
  assign ic_avail    = ic_pending && !ic_rsp_valid;
  assign dc_avail    = dc_pending && !dc_rsp_valid;
  assign timeout_hit = (timer_reg == TIMER_LAST);
  assign rsp_data    = mem_rsp_valid ? mem_rsp_data : '0;
  assign rsp_err     = mem_rsp_valid ? mem_rsp_bus_error : 1'b1;

  always_comb begin
    pick = REQ_DC;
    if (ic_avail && dc_avail) begin
      pick = (last_reg == REQ_DC) ? REQ_IC : REQ_DC;
    end else if (ic_avail) begin
      pick = REQ_IC;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_reg        <= IDLE;
      grant_reg        <= REQ_DC;
      last_reg         <= REQ_IC;
      timer_reg        <= '0;
      mem_req_valid    <= 1'b0;
      mem_req_info     <= '0;
      ic_rsp_valid     <= 1'b0;
      ic_rsp_data      <= '0;
      ic_rsp_bus_error <= 1'b0;
      dc_rsp_valid     <= 1'b0;
      dc_rsp_data      <= '0;
      dc_rsp_bus_error <= 1'b0;
    end else begin
      ic_rsp_valid <= 1'b0;
      dc_rsp_valid <= 1'b0;
      unique case (state_reg)
        IDLE: begin
          if (ic_avail || dc_avail) begin
            grant_reg     <= pick;
            mem_req_valid <= 1'b1;
            mem_req_info  <= (pick == REQ_IC) ? {ic_addr, 1'b0, {LINE_W{1'b0}}} : dc_info;
            state_reg     <= ISSUE;
          end
        end
        ISSUE: begin
          if (mem_req_ready) begin
            mem_req_valid <= 1'b0;
            timer_reg     <= '0;
            state_reg     <= WAIT_RSP;
          end
        end
        WAIT_RSP: begin
          timer_reg <= timer_reg + TIMER_W'(1);
          // A real response in the timeout cycle still wins over the forced error.
          if (mem_rsp_valid || timeout_hit) begin
            if (grant_reg == REQ_IC) begin
              ic_rsp_valid     <= 1'b1;
              ic_rsp_data      <= rsp_data;
              ic_rsp_bus_error <= rsp_err;
            end else begin
              dc_rsp_valid     <= 1'b1;
              dc_rsp_data      <= rsp_data;
              dc_rsp_bus_error <= rsp_err;
            end
            last_reg  <= grant_reg;
            state_reg <= mem_rsp_valid ? IDLE : DRAIN;
          end
        end
        DRAIN: begin
          if (mem_rsp_valid) begin
            state_reg <= IDLE;
          end
        end
        default: state_reg <= IDLE;
      endcase
      assert (!(mem_rsp_valid && (state_reg == IDLE || state_reg == ISSUE)));
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Randomized and directed bench for mem_arbiter against a cycle-level reference model.
module tb_mem_arbiter;

  localparam int AW = 20;
  localparam int LW = 128;
  localparam int IW = AW + 1 + LW;
  localparam int T  = 8;

  logic          clock = 1'b0;
  logic          reset = 1'b1;
  logic          ic_req_valid = 1'b0;
  logic [AW-1:0] ic_req_addr = '0;
  logic          ic_rsp_valid;
  logic [LW-1:0] ic_rsp_data;
  logic          ic_rsp_bus_error;
  logic          dc_req_valid = 1'b0;
  logic [IW-1:0] dc_req_info = '0;
  logic          dc_rsp_valid;
  logic [LW-1:0] dc_rsp_data;
  logic          dc_rsp_bus_error;
  logic          mem_req_valid;
  logic          mem_req_ready = 1'b0;
  logic [IW-1:0] mem_req_info;
  logic          mem_rsp_valid = 1'b0;
  logic [LW-1:0] mem_rsp_data = '0;
  logic          mem_rsp_bus_error = 1'b0;

  always #5 clock = ~clock;

  mem_arbiter #(.ADDR_W(AW), .LINE_W(LW), .TIMEOUT_CYCLES(T)) dut (
    .clock             (clock),
    .reset             (reset),
    .ic_req_valid      (ic_req_valid),
    .ic_req_addr       (ic_req_addr),
    .ic_rsp_valid      (ic_rsp_valid),
    .ic_rsp_data       (ic_rsp_data),
    .ic_rsp_bus_error  (ic_rsp_bus_error),
    .dc_req_valid      (dc_req_valid),
    .dc_req_info       (dc_req_info),
    .dc_rsp_valid      (dc_rsp_valid),
    .dc_rsp_data       (dc_rsp_data),
    .dc_rsp_bus_error  (dc_rsp_bus_error),
    .mem_req_valid     (mem_req_valid),
    .mem_req_ready     (mem_req_ready),
    .mem_req_info      (mem_req_info),
    .mem_rsp_valid     (mem_rsp_valid),
    .mem_rsp_data      (mem_rsp_data),
    .mem_rsp_bus_error (mem_rsp_bus_error)
  );

  int tests = 0;
  int fails = 0;
  int cyc   = 0;

  // Reference model, index 0 = icache, 1 = dcache. Phase: 0 free, 1 offering,
  // 2 outstanding (answer allowed up to hs+T), 3 discarding the late answer.
  logic          m_pend[2];
  logic [IW-1:0] m_info[2];
  logic          m_rv[2];
  logic [LW-1:0] m_rd[2];
  logic          m_re[2];
  logic          m_req;
  logic [IW-1:0] m_req_info;
  int            m_phase, m_owner, m_last, m_hs;

  // Memory agent controls
  int            rsp_due   = -1;
  int            delay_sel = 3;
  bit            fix_data  = 1'b1;
  logic [LW-1:0] fixed_data = {16{8'hA5}};
  bit            fixed_err = 1'b0;
  bit            rand_ready = 1'b0;

  task automatic chk(input string name, input logic [IW-1:0] got, input logic [IW-1:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s cycle %0d: got %h required %h", name, cyc, got, exp);
    end
  endtask

  task automatic cycle();
    logic          n_pend[2];
    logic [IW-1:0] n_info[2];
    logic          n_rv[2];
    logic [LW-1:0] n_rd[2];
    logic          n_re[2];
    logic          n_req;
    logic [IW-1:0] n_req_info;
    int            n_phase, n_owner, n_last, n_hs;
    logic          pulse[2];
    logic [IW-1:0] pinfo[2];
    logic          a0, a1;
    pulse[0] = ic_req_valid;  pinfo[0] = {ic_req_addr, 1'b0, {LW{1'b0}}};
    pulse[1] = dc_req_valid;  pinfo[1] = dc_req_info;
    n_pend = m_pend; n_info = m_info; n_rd = m_rd; n_re = m_re;
    n_rv = '{1'b0, 1'b0};
    n_req = m_req; n_req_info = m_req_info;
    n_phase = m_phase; n_owner = m_owner; n_last = m_last; n_hs = m_hs;
    a0 = m_pend[0] && !m_rv[0];
    a1 = m_pend[1] && !m_rv[1];
    case (m_phase)
      0: if (a0 || a1) begin
        n_owner    = (a0 && a1) ? 1 - m_last : (a1 ? 1 : 0);
        n_req      = 1'b1;
        n_req_info = m_info[n_owner];
        n_phase    = 1;
      end
      1: if (mem_req_ready) begin
        n_req   = 1'b0;
        n_phase = 2;
        n_hs    = cyc;
        rsp_due = cyc + delay_sel;
      end
      2: if (mem_rsp_valid || cyc == m_hs + T) begin
        n_rv[m_owner] = 1'b1;
        n_rd[m_owner] = mem_rsp_valid ? mem_rsp_data : '0;
        n_re[m_owner] = mem_rsp_valid ? mem_rsp_bus_error : 1'b1;
        n_last  = m_owner;
        n_phase = mem_rsp_valid ? 0 : 3;
      end
      default: if (mem_rsp_valid) n_phase = 0;
    endcase
    for (int i = 0; i < 2; i++) begin
      if (pulse[i] && (!m_pend[i] || m_rv[i])) begin
        n_pend[i] = 1'b1;
        n_info[i] = pinfo[i];
      end else if (m_rv[i]) begin
        n_pend[i] = 1'b0;
      end
    end
    if (reset) begin
      n_pend = '{1'b0, 1'b0}; n_info = '{'0, '0}; n_rv = '{1'b0, 1'b0};
      n_rd = '{'0, '0}; n_re = '{1'b0, 1'b0}; n_req = 1'b0; n_req_info = '0;
      n_phase = 0; n_owner = 1; n_last = 0; n_hs = 0;
    end
    @(posedge clock);
    #1;
    m_pend = n_pend; m_info = n_info; m_rv = n_rv; m_rd = n_rd; m_re = n_re;
    m_req = n_req; m_req_info = n_req_info;
    m_phase = n_phase; m_owner = n_owner; m_last = n_last; m_hs = n_hs;
    cyc++;
    chk("mem_req_valid", mem_req_valid, m_req);
    if (m_req) chk("mem_req_info", mem_req_info, m_req_info);
    chk("ic_rsp_valid", ic_rsp_valid, m_rv[0]);
    chk("ic_rsp_data", ic_rsp_data, m_rd[0]);
    chk("ic_rsp_bus_error", ic_rsp_bus_error, m_re[0]);
    chk("dc_rsp_valid", dc_rsp_valid, m_rv[1]);
    chk("dc_rsp_data", dc_rsp_data, m_rd[1]);
    chk("dc_rsp_bus_error", dc_rsp_bus_error, m_re[1]);
    ic_req_valid  = 1'b0;
    dc_req_valid  = 1'b0;
    mem_rsp_valid = 1'b0;
  endtask

  task automatic step();
    mem_rsp_valid     = (m_phase == 2 || m_phase == 3) && (cyc == rsp_due);
    mem_rsp_data      = fix_data ? fixed_data : {$urandom, $urandom, $urandom, $urandom};
    mem_rsp_bus_error = fix_data ? fixed_err : ($urandom_range(0, 7) == 0);
    if (rand_ready) mem_req_ready = ($urandom_range(0, 1) == 1);
    cycle();
  endtask

  task automatic pulse_ic(input logic [AW-1:0] addr);
    ic_req_valid = 1'b1;
    ic_req_addr  = addr;
  endtask

  task automatic pulse_dc(input logic [AW-1:0] addr, input logic st, input logic [LW-1:0] line);
    dc_req_valid = 1'b1;
    dc_req_info  = {addr, st, line};
  endtask

  task automatic wait_req(output int at);
    int k = 0;
    while (!mem_req_valid && k < 60) begin
      step();
      k++;
    end
    tests++;
    if (!mem_req_valid) begin
      fails++;
      $display("FAIL wait_req cycle %0d: mem_req_valid still 0 after %0d cycles", cyc, k);
    end
    at = cyc;
  endtask

  task automatic wait_rsp(input int side, output int at);
    int k = 0;
    while (!(side == 0 ? ic_rsp_valid : dc_rsp_valid) && k < 60) begin
      step();
      k++;
    end
    tests++;
    if (!(side == 0 ? ic_rsp_valid : dc_rsp_valid)) begin
      fails++;
      $display("FAIL wait_rsp cycle %0d: side %0d rsp_valid still 0 after %0d cycles", cyc, side, k);
    end
    at = cyc;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    mem_req_ready = 1'b0;
    step();
    step();
    reset = 1'b0;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int at, at2, r, hs;
    m_phase = 0;
    do_reset();

    // A: single dcache read
    mem_req_ready = 1'b1; delay_sel = 3;
    pulse_dc(20'h00012, 1'b0, '0);
    at2 = cyc;
    step();
    wait_req(at);
    chk("A_req_latency", at, at2 + 2);
    chk("A_req_info", mem_req_info, {20'h00012, 1'b0, 128'h0});
    step();
    wait_rsp(1, r);
    chk("A_rsp_latency", r, at + 4);
    chk("A_rsp_data", dc_rsp_data, {16{8'hA5}});
    step();

    // B: simultaneous pulses, round-robin order
    do_reset();
    mem_req_ready = 1'b1; delay_sel = 2;
    pulse_ic(20'h00111); pulse_dc(20'h00222, 1'b0, '0);
    step();
    wait_req(at); chk("B1_first_dc", mem_req_info[IW-1 -: AW], 20'h00222); step();
    wait_req(at); chk("B1_second_ic", mem_req_info[IW-1 -: AW], 20'h00111); step();
    wait_rsp(0, r); step();
    pulse_dc(20'h00333, 1'b0, '0); step();
    wait_req(at); step(); wait_rsp(1, r); step();
    pulse_ic(20'h00444); pulse_dc(20'h00555, 1'b0, '0);
    step();
    wait_req(at); chk("B2_first_ic", mem_req_info[IW-1 -: AW], 20'h00444); step();
    wait_req(at); chk("B2_second_dc", mem_req_info[IW-1 -: AW], 20'h00555); step();
    wait_rsp(1, r); step();

    // C: evict answered, bring_line pulsed in the response cycle
    pulse_dc(20'h00600, 1'b1, {4{32'hDEADBEEF}}); step();
    wait_req(at); chk("C_evict_info", mem_req_info, {20'h00600, 1'b1, {4{32'hDEADBEEF}}}); step();
    wait_rsp(1, r);
    pulse_dc(20'h00601, 1'b0, '0); step();
    wait_req(at);
    chk("C_bring_latency", at, r + 2);
    chk("C_bring_addr", mem_req_info[IW-1 -: AW], 20'h00601);
    step(); wait_rsp(1, r); step();

    // D: ready withheld for 10 cycles, then answer in the last allowed cycle
    mem_req_ready = 1'b0; delay_sel = T;
    pulse_dc(20'h00700, 1'b0, '0); step();
    wait_req(at);
    for (int k = 0; k < 10; k++) begin
      step();
      chk("D_hold_valid", mem_req_valid, 1'b1);
      chk("D_hold_info", mem_req_info, {20'h00700, 1'b0, 128'h0});
    end
    mem_req_ready = 1'b1; hs = cyc;
    step();
    wait_rsp(1, r);
    chk("D_rsp_latency", r, hs + T + 1);
    chk("D_rsp_no_err", dc_rsp_bus_error, 1'b0);
    step();

    // E: memory silent -> timeout error, late answer drained, icache proceeds
    delay_sel = T + 4;
    pulse_dc(20'h00800, 1'b0, '0); step();
    pulse_ic(20'h00900); step();
    wait_req(at); chk("E_dc_addr", mem_req_info[IW-1 -: AW], 20'h00800);
    hs = at;
    step(); delay_sel = 3;
    wait_rsp(1, r);
    chk("E_timeout_latency", r, hs + T + 1);
    chk("E_timeout_err", dc_rsp_bus_error, 1'b1);
    chk("E_timeout_data", dc_rsp_data, 128'h0);
    wait_req(at);
    chk("E_next_issue", at, hs + T + 6);
    chk("E_ic_addr", mem_req_info[IW-1 -: AW], 20'h00900);
    step(); wait_rsp(0, r); step();

    // F: bus error on icache read, pending dcache served next
    fixed_err = 1'b1;
    pulse_ic(20'h00A00); step();
    pulse_dc(20'h00B00, 1'b1, {4{32'h12345678}}); step();
    wait_req(at); chk("F_ic_addr", mem_req_info[IW-1 -: AW], 20'h00A00); step();
    wait_rsp(0, r);
    chk("F_ic_err", ic_rsp_bus_error, 1'b1);
    fixed_err = 1'b0;
    wait_req(at);
    chk("F_dc_latency", at, r + 1);
    chk("F_dc_info", mem_req_info, {20'h00B00, 1'b1, {4{32'h12345678}}});
    step();
    wait_rsp(1, r);
    chk("F_dc_no_err", dc_rsp_bus_error, 1'b0);
    step();

    // Random traffic
    fix_data = 1'b0; rand_ready = 1'b1;
    for (int k = 0; k < 3000; k++) begin
      if ((!m_pend[0] || m_rv[0]) && $urandom_range(0, 3) == 0) pulse_ic(AW'($urandom));
      if ((!m_pend[1] || m_rv[1]) && $urandom_range(0, 3) == 0)
        pulse_dc(AW'($urandom), 1'($urandom_range(0, 1)), {$urandom, $urandom, $urandom, $urandom});
      delay_sel = $urandom_range(1, T + 3);
      step();
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
